instr_fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the ARM7 core. It replaces the phase-counter fetch with a decoupled prefetch queue. It issues word requests to the instruction cache through a split request/response handshake and buffers up to DEPTH fetched words, each tagged with its address. It hands them to the decoder through a valid/ready handshake. A single-cycle redirect from execute (branch, exception) flushes the queue and discards any response still in flight.

---
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the instruction-cache request/response handshake,
//               the decoder valid/ready handshake and the execute redirect
//               for instr_fetch_unit.
//               master : fetch unit side (drives imem_req/addr, dec_*)
//               slave  : cache + decoder + execute side
// Ports       : imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata,
//               dec_valid, dec_ready, dec_instr, dec_pc,
//               redirect, redirect_pc
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        output imem_gnt, imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Decoupled instruction prefetch front-end. Issues one word
//               request at a time to the instruction cache, buffers up to
//               DEPTH returned words (tagged with their fetch address) and
//               presents them to the decoder over valid/ready. A redirect
//               flushes the queue and discards any response still in flight.
// Ports       : clk, rst_n (async, active low), bus_io (master modport of
//               instr_fetch_unit_if: imem_*, dec_*, redirect*)
// Options     : IFU_BYPASS_EN - when defined, a response arriving while the
//               queue is empty is offered to the decoder in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instr_fetch_unit_if.master     bus_io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    localparam logic [CNT_W-1:0]  c_DEPTH   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic w_byp;
    logic w_push;
    logic w_pop;

    // Same-cycle hand-off of a response straight to the decoder.
`ifdef IFU_BYPASS_EN
    assign w_byp = (count_q == '0) && (state_q == c_ST_WAIT) && bus_io.imem_rvalid;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed word that the decoder takes is never written to the queue.
    assign w_push = (state_q == c_ST_WAIT) && bus_io.imem_rvalid && !bus_io.redirect
                    && !(w_byp && bus_io.dec_ready);
    // Bypass only happens with an empty queue, so a pop always means a real entry.
    assign w_pop  = (count_q != '0) && !bus_io.redirect && bus_io.dec_ready;

    // Queue bookkeeping and fetch address tracking.
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if ((state_q == c_ST_REQ) && bus_io.imem_gnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + c_PC_STEP;
        end
        if (bus_io.redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {bus_io.redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (w_push) begin
                instr_mem_q[wr_ptr_q] <= bus_io.imem_rdata;
                pc_mem_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus_io.redirect || (count_q < c_DEPTH)) state_d = c_ST_REQ;
            end
            c_ST_REQ: begin
                // A grant alongside a redirect leaves a stale response owed.
                if (bus_io.imem_gnt) state_d = bus_io.redirect ? c_ST_DROP : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // count_d is already zero on a redirect, so REQ is chosen then.
                if (bus_io.imem_rvalid)   state_d = (count_d < c_DEPTH) ? c_ST_REQ : c_ST_IDLE;
                else if (bus_io.redirect) state_d = c_ST_DROP;
            end
            c_ST_DROP: begin
                // A redirect here changes nothing: one stale response is still
                // owed and swallowing it always restarts at the latest fetch_pc.
                if (bus_io.imem_rvalid) state_d = c_ST_REQ;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus_io.imem_req  = (state_q == c_ST_REQ);
        bus_io.imem_addr = fetch_pc_q;
        bus_io.dec_valid = ((count_q != '0) || w_byp) && !bus_io.redirect;
`ifdef IFU_BYPASS_EN
        bus_io.dec_instr = w_byp ? bus_io.imem_rdata : instr_mem_q[rd_ptr_q];
        bus_io.dec_pc    = w_byp ? req_pc_q          : pc_mem_q[rd_ptr_q];
`else
        bus_io.dec_instr = instr_mem_q[rd_ptr_q];
        bus_io.dec_pc    = pc_mem_q[rd_ptr_q];
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               small instruction-memory responder of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

`ifdef IFU_BYPASS_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    int          mem_lat;
    int          n_gnt;

    function automatic logic [31:0] img(input logic [31:0] a);
        return 32'hE3A0_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and drive the memory response for the
    // coming posedge: rvalid mem_lat cycles after the grant cycle.
    task automatic step();
        @(negedge clk);
        if (pend) begin
            if (wait_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = img(pend_addr);
                pend            = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                wait_cnt--;
            end
        end else begin
            bus.imem_rvalid = 1'b0;
        end
        bus.imem_gnt = bus.imem_req;
        if (bus.imem_gnt) begin
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
            wait_cnt  = mem_lat - 1;
            n_gnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        pend            = 1'b0;
        n_gnt           = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Wait (bounded) for dec_valid and check the presented word.
    task automatic expect_next(input string tag, input logic [31:0] pc, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.dec_valid) break;
            step();
        end
        chk({tag, "_valid"}, 32'(bus.dec_valid), 32'd1);
        chk({tag, "_pc"},    bus.dec_pc,         pc);
        chk({tag, "_instr"}, bus.dec_instr,      img(pc));
    endtask

    initial begin
        int k;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.dec_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        pend            = 1'b0;
        pend_addr       = '0;
        wait_cnt        = 0;
        mem_lat         = 1;
        n_gnt           = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(bus.imem_req),  32'd0);
        chk("rst_addr",  bus.imem_addr,      32'h0);
        chk("rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_instr", bus.dec_instr,      32'h0);
        chk("rst_pc",    bus.dec_pc,         32'h0);

        // Streaming with 1-cycle memory and a ready decoder
        bus.dec_ready = 1'b1;
        do_reset();
        step();
        chk("c1_req",  32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr,     32'h0);
        k = 1;
        while (!bus.dec_valid && k < 10) begin
            step();
            k++;
        end
        chk("first_valid_cycle", 32'(k), 32'(EXP_LAT));
        expect_next("s0", 32'h0, 1);
        step();
        expect_next("s4", 32'h4, 6);
        step();
        expect_next("s8", 32'h8, 6);
        step();
        expect_next("sC", 32'hC, 6);

        // Decoder stalled: exactly DEPTH fetches, then request stays low
        bus.dec_ready = 1'b0;
        do_reset();
        repeat (20) step();
        chk("stall_gnts",  32'(n_gnt),        32'd4);
        chk("stall_req",   32'(bus.imem_req), 32'd0);
        chk("stall_valid", 32'(bus.dec_valid), 32'd1);
        chk("stall_pc",    bus.dec_pc,        32'h0);
        bus.dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.dec_valid), 32'd1);
            chk("drain_pc",    bus.dec_pc,         32'(4 * i));
            step();
        end
        expect_next("resume10", 32'h10, 10);

        // Redirect during WAIT (no rvalid yet) -> DROP
        mem_lat = 3;
        do_reset();
        step();
        step();
        chk("w_noreq", 32'(bus.imem_req), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        #1;
        chk("w_redir_valid", 32'(bus.dec_valid), 32'd0);
        mem_lat = 1;
        step();
        bus.redirect = 1'b0;
        #1;
        chk("drop_req1", 32'(bus.imem_req), 32'd0);
        step();
        chk("drop_req2", 32'(bus.imem_req), 32'd0);
        step();
        chk("w_new_req",  32'(bus.imem_req), 32'd1);
        chk("w_new_addr", bus.imem_addr,     32'h100);
        expect_next("w_first", 32'h100, 10);

        // Redirect in the same cycle as imem_gnt
        do_reset();
        step();
        chk("g_req", 32'(bus.imem_req), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        #1;
        chk("g_drop_req",   32'(bus.imem_req),  32'd0);
        chk("g_drop_valid", 32'(bus.dec_valid), 32'd0);
        step();
        chk("g_new_req",  32'(bus.imem_req), 32'd1);
        chk("g_new_addr", bus.imem_addr,     32'h200);
        expect_next("g_first", 32'h200, 10);

        // Redirect in the same cycle as imem_rvalid with a non-empty queue
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_rvalid) break;
            step();
        end
        chk("r_rvalid",  32'(bus.imem_rvalid), 32'd1);
        chk("r_queued",  32'(bus.dec_valid),   32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        #1;
        chk("r_gate_valid", 32'(bus.dec_valid), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        chk("r_flushed",  32'(bus.dec_valid), 32'd0);
        chk("r_new_req",  32'(bus.imem_req),  32'd1);
        chk("r_new_addr", bus.imem_addr,      32'h300);
        bus.dec_ready = 1'b1;
        expect_next("r_first", 32'h300, 10);

        // Redirect near the top of the address space; low bits ignored
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("wrap_gate", 32'(bus.dec_valid), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        expect_next("wrap_top", 32'hFFFF_FFFC, 12);
        step();
        expect_next("wrap_zero", 32'h0, 12);

        // Asynchronous reset mid-WAIT with two entries queued
        mem_lat       = 3;
        bus.dec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (n_gnt == 3) break;
            step();
        end
        chk("ar_gnts", 32'(n_gnt), 32'd3);
        step();
        chk("ar_pre_req",   32'(bus.imem_req),  32'd0);
        chk("ar_pre_valid", 32'(bus.dec_valid), 32'd1);
        chk("ar_pre_addr",  bus.imem_addr,      32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   32'(bus.imem_req),  32'd0);
        chk("ar_addr",  bus.imem_addr,      32'h0);
        chk("ar_valid", 32'(bus.dec_valid), 32'd0);
        chk("ar_instr", bus.dec_instr,      32'h0);
        chk("ar_pc",    bus.dec_pc,         32'h0);
        pend            = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        mem_lat       = 1;
        bus.dec_ready = 1'b1;
        rst_n         = 1'b1;
        #1;
        step();
        chk("ar_restart_req",  32'(bus.imem_req), 32'd1);
        chk("ar_restart_addr", bus.imem_addr,     32'h0);
        expect_next("ar_first", 32'h0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
